// File: rtl/nibble_sub_pkg.sv
// Shared constants and types for the nibble-serial 16-bit subtractor.
// Optional feature macro: NIBBLE_SUB_SAT_EN (saturate diff on signed overflow).
package nibble_sub_pkg;

  localparam int unsigned NIB_W   = 4;
  localparam int unsigned NUM_NIB = 4;
  localparam int unsigned DATA_W  = 16;
  localparam int unsigned IDX_W   = 2;
  localparam int unsigned RAW_W   = DATA_W - NIB_W;

  localparam logic [DATA_W-1:0] SAT_POS = 16'h7FFF;
  localparam logic [DATA_W-1:0] SAT_NEG = 16'h8000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Saturation bound chosen by the sign of the minuend.
  function automatic logic [DATA_W-1:0] sat_value(input logic a_msb);
    return a_msb ? SAT_NEG : SAT_POS;
  endfunction

endpackage

// File: rtl/sub_slice4.sv
// Combinational 4-bit carry-lookahead adder slice used for a + ~b + cin.
module sub_slice4
  import nibble_sub_pkg::*;
(
  input  logic [NIB_W-1:0] a,
  input  logic [NIB_W-1:0] b,
  input  logic             cin,
  output logic [NIB_W-1:0] sum,
  output logic             cout
);

  logic [NIB_W-1:0] g;
  logic [NIB_W-1:0] p;
  logic [NIB_W-1:0] c;

  assign g = a & b;
  assign p = a ^ b;

  // Lookahead carries computed directly from generate/propagate terms.
  assign c[0] = cin;
  assign c[1] = g[0] | (p[0] & cin);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & cin);
  assign cout = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & cin);

  assign sum = p ^ c;

endmodule

// File: rtl/nibble_serial_sub16.sv
// Nibble-serial 16-bit subtractor: diff = a - b over four cycles with Z/V/N flags.
// Optional feature macro: NIBBLE_SUB_SAT_EN (clamp diff to 0x7FFF/0x8000 on overflow).
module nibble_serial_sub16
  import nibble_sub_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] diff,
  output logic              ovfl,
  output logic              zero,
  output logic              neg
);

  state_t            state;
  logic [IDX_W-1:0]  idx;
  logic              carry_q;
  logic [DATA_W-1:0] a_q;
  logic [DATA_W-1:0] nb_q;
  logic [RAW_W-1:0]  raw_q;

  logic [NIB_W-1:0]  sum_c;
  logic              cout_c;
  logic [DATA_W-1:0] raw_c;
  logic [DATA_W-1:0] fin_c;
  logic              v_c;

  // Single shared slice; the operand nibble is selected by idx.
  sub_slice4 u_slice (
    .a    (a_q[NIB_W*idx +: NIB_W]),
    .b    (nb_q[NIB_W*idx +: NIB_W]),
    .cin  (carry_q),
    .sum  (sum_c),
    .cout (cout_c)
  );

  // Top nibble comes straight from the slice on the finalize edge.
  assign raw_c = {sum_c, raw_q};

  // nb_q holds ~b, so a[15] != b[15] is equivalent to a_q[15] == nb_q[15].
  assign v_c = (a_q[DATA_W-1] == nb_q[DATA_W-1]) & (raw_c[DATA_W-1] != a_q[DATA_W-1]);

`ifdef NIBBLE_SUB_SAT_EN
  assign fin_c = v_c ? sat_value(a_q[DATA_W-1]) : raw_c;
`else
  assign fin_c = raw_c;
`endif

  // Control FSM with the operand, shift and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      idx     <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      nb_q    <= '0;
      raw_q   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      diff    <= '0;
      ovfl    <= 1'b0;
      zero    <= 1'b0;
      neg     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_q     <= a;
            nb_q    <= ~b;
            carry_q <= 1'b1;
            idx     <= '0;
            busy    <= 1'b1;
            state   <= RUN;
          end
        end
        RUN: begin
          raw_q   <= {sum_c, raw_q[RAW_W-1:NIB_W]};
          carry_q <= cout_c;
          if (idx == IDX_W'(NUM_NIB - 1)) begin
            idx   <= '0;
            diff  <= fin_c;
            ovfl  <= v_c;
            zero  <= (fin_c == '0);
            neg   <= fin_c[DATA_W-1];
            done  <= 1'b1;
            state <= DONE;
          end else begin
            idx <= idx + IDX_W'(1);
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_serial_sub16.sv
// Directed self-checking bench for nibble_serial_sub16.
// Expectations follow NIBBLE_SUB_SAT_EN when the bench is built with it.
module tb_nibble_serial_sub16;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] a;
  logic [15:0] b;
  logic        busy;
  logic        done;
  logic [15:0] diff;
  logic        ovfl;
  logic        zero;
  logic        neg;

  int errors;
  int checks;

`ifdef NIBBLE_SUB_SAT_EN
  localparam logic [15:0] EXP_7FFF_M_FFFF = 16'h7FFF;
  localparam logic [15:0] EXP_8000_M_0001 = 16'h8000;
`else
  localparam logic [15:0] EXP_7FFF_M_FFFF = 16'h8000;
  localparam logic [15:0] EXP_8000_M_0001 = 16'h7FFF;
`endif

  nibble_serial_sub16 dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .ovfl  (ovfl),
    .zero  (zero),
    .neg   (neg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse start for one cycle and return the start-to-done latency (-1 on timeout).
  task automatic launch(input logic [15:0] av, input logic [15:0] bv, output int lat);
    @(negedge clk);
    a = av;
    b = bv;
    start = 1'b1;
    lat = -1;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (done) begin
        lat = c;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b0;
    a = 16'h0;
    b = 16'h0;
    repeat (2) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
    checks++; if (diff !== 16'h0000) begin errors++; $display("FAIL reset_diff got %h want 0000", diff); end
    checks++; if ({ovfl, zero, neg} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b want 000", {ovfl, zero, neg}); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  // 5 - 3 with cycle-by-cycle busy/done tracking.
  task automatic test_basic();
    @(negedge clk);
    a = 16'h0005;
    b = 16'h0003;
    start = 1'b1;
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      start = 1'b0;
      checks++;
      if (busy !== (c <= 5)) begin errors++; $display("FAIL basic_busy cyc=%0d got %b want %b", c, busy, (c <= 5)); end
      checks++;
      if (done !== (c == 5)) begin errors++; $display("FAIL basic_done cyc=%0d got %b want %b", c, done, (c == 5)); end
      if (c == 5) begin
        checks++; if (diff !== 16'h0002) begin errors++; $display("FAIL basic_diff got %h want 0002", diff); end
        checks++; if ({ovfl, zero, neg} !== 3'b000) begin errors++; $display("FAIL basic_flags got %b want 000", {ovfl, zero, neg}); end
      end
      if (c == 7) begin
        checks++; if (diff !== 16'h0002) begin errors++; $display("FAIL basic_hold got %h want 0002", diff); end
      end
    end
  endtask

  // Directed operand table: equal operands, overflow both ways, full borrow chains.
  task automatic test_arith();
    logic [15:0] ta [6];
    logic [15:0] tb_ [6];
    logic [15:0] td [6];
    logic [2:0]  tf [6];
    int lat;
    ta[0] = 16'h1234; tb_[0] = 16'h1234; td[0] = 16'h0000;          tf[0] = 3'b010;
    ta[1] = 16'h7FFF; tb_[1] = 16'hFFFF; td[1] = EXP_7FFF_M_FFFF;   tf[1] = {1'b1, 1'b0, EXP_7FFF_M_FFFF[15]};
    ta[2] = 16'h8000; tb_[2] = 16'h0001; td[2] = EXP_8000_M_0001;   tf[2] = {1'b1, 1'b0, EXP_8000_M_0001[15]};
    ta[3] = 16'h1000; tb_[3] = 16'h0001; td[3] = 16'h0FFF;          tf[3] = 3'b000;
    ta[4] = 16'h0000; tb_[4] = 16'h0001; td[4] = 16'hFFFF;          tf[4] = 3'b001;
    ta[5] = 16'hA5C3; tb_[5] = 16'h1F0E; td[5] = 16'h86B5;          tf[5] = 3'b001;
    for (int i = 0; i < 6; i++) begin
      launch(ta[i], tb_[i], lat);
      checks++; if (lat !== 5) begin errors++; $display("FAIL arith%0d_latency got %0d want 5", i, lat); end
      checks++; if (diff !== td[i]) begin errors++; $display("FAIL arith%0d_diff got %h want %h", i, diff, td[i]); end
      checks++; if ({ovfl, zero, neg} !== tf[i]) begin errors++; $display("FAIL arith%0d_vzn got %b want %b", i, {ovfl, zero, neg}, tf[i]); end
    end
  endtask

  // Start pulses during RUN and DONE must be dropped.
  task automatic test_ignore_start();
    int dcnt;
    int dcyc;
    logic [15:0] dval;
    int lat;
    dcnt = 0;
    dcyc = 0;
    dval = 16'hxxxx;
    @(negedge clk);
    a = 16'h0009;
    b = 16'h0004;
    start = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (c == 2 || c == 5) begin
        a = 16'h0001;
        b = 16'h0001;
        start = 1'b1;
      end
      if (done) begin
        dcnt++;
        dcyc = c;
        dval = diff;
      end
      if (c == 7) begin
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ignore_busy got %b want 0", busy); end
      end
    end
    checks++; if (dcnt !== 1) begin errors++; $display("FAIL ignore_done_count got %0d want 1", dcnt); end
    checks++; if (dcyc !== 5) begin errors++; $display("FAIL ignore_done_cycle got %0d want 5", dcyc); end
    checks++; if (dval !== 16'h0005) begin errors++; $display("FAIL ignore_diff got %h want 0005", dval); end
    launch(16'h0001, 16'h0001, lat);
    checks++; if (lat !== 5) begin errors++; $display("FAIL ignore_next_latency got %0d want 5", lat); end
    checks++; if ({diff, zero} !== {16'h0000, 1'b1}) begin errors++; $display("FAIL ignore_next_result got %h/%b want 0000/1", diff, zero); end
  endtask

  // Start held high: one operation per six cycles.
  task automatic test_back_to_back();
    int dcnt;
    int d0;
    int d1;
    dcnt = 0;
    d0 = 0;
    d1 = 0;
    @(negedge clk);
    a = 16'h0010;
    b = 16'h0001;
    start = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (done) begin
        if (dcnt == 0) d0 = c; else d1 = c;
        dcnt++;
      end
    end
    start = 1'b0;
    checks++; if (dcnt !== 2) begin errors++; $display("FAIL b2b_done_count got %0d want 2", dcnt); end
    checks++; if ({d0, d1} !== {32'd5, 32'd11}) begin errors++; $display("FAIL b2b_done_cycles got %0d,%0d want 5,11", d0, d1); end
    checks++; if (diff !== 16'h000F) begin errors++; $display("FAIL b2b_diff got %h want 000F", diff); end
    repeat (2) @(negedge clk);
  endtask

  // Async reset in the second RUN cycle discards the operation.
  task automatic test_reset_mid_run();
    int dcnt;
    int lat;
    dcnt = 0;
    @(negedge clk);
    a = 16'h00FF;
    b = 16'h0001;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++; if ({busy, diff} !== {1'b1, 16'h000F}) begin errors++; $display("FAIL rstrun_pre got busy=%b diff=%h want 1/000F", busy, diff); end
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstrun_busy got %b want 0", busy); end
    checks++; if (diff !== 16'h0000) begin errors++; $display("FAIL rstrun_diff got %h want 0000", diff); end
    checks++; if ({done, ovfl, zero, neg} !== 4'b0000) begin errors++; $display("FAIL rstrun_flags got %b want 0000", {done, ovfl, zero, neg}); end
    @(negedge clk);
    rst = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (done || busy) dcnt++;
    end
    checks++; if (dcnt !== 0) begin errors++; $display("FAIL rstrun_no_done got %0d active cycles want 0", dcnt); end
    launch(16'h4000, 16'h2000, lat);
    checks++; if (lat !== 5) begin errors++; $display("FAIL rstrun_fresh_latency got %0d want 5", lat); end
    checks++; if ({diff, ovfl, zero, neg} !== {16'h2000, 3'b000}) begin errors++; $display("FAIL rstrun_fresh got %h/%b want 2000/000", diff, {ovfl, zero, neg}); end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_basic();
    test_arith();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid_run();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/nibble_serial_sub16.md
# nibble_serial_sub16

- Sequential 16-bit two's-complement subtractor: computes `diff = a - b` one 4-bit nibble per cycle, using a single 4-bit carry-lookahead subtract slice.
- Borrow propagates between cycles through a carry register.
- Sits beside the ALU as a low-area subtract path. It produces `diff` plus Z/V/N flags, with optional WISC-style saturation on overflow.
- Uses a start/done handshake, so the issuing logic stalls on `busy`.

## Interface
Parameters:
- none; widths fixed at 16 bits / 4 nibbles (constants in package).

Ports:
- `clk`  in  1  — single clock.
- `rst`  in  1  — asynchronous, active-high reset.
- `start`  in  1  — request; sampled only in IDLE.
- `a`  in  16  — minuend; captured on accepted start.
- `b`  in  16  — subtrahend; captured on accepted start.
- `busy`  out  1  — high in RUN and DONE.
- `done`  out  1  — one-cycle pulse; `diff`/flags valid from this cycle.
- `diff`  out  16  — result.
- `ovfl`  out  1  — signed overflow (V).
- `zero`  out  1  — `diff == 0`.
- `neg`  out  1  — `diff[15]`.

## Operation
States:
- **IDLE**: on `start`=1, latch `a` into `a_q` and `~b` into `nb_q`; `carry_q`=1, `idx`=0; go to RUN. `start`=0 stays IDLE.
- **RUN**: each edge, the slice adds `a_q[4*idx+:4] + nb_q[4*idx+:4] + carry_q`.
  - Write the 4-bit sum into `raw_q[4*idx+:4]`.
  - `carry_q` takes the slice carry-out; `idx` increments.
  - When `idx`==3 at the edge: finalize and go to DONE.
- **Finalize** (same edge as the idx-3 nibble):
  - V = (`a_q[15]` != `b[15]` captured) & (`raw[15]` != `a_q[15]`).
  - Load `diff` (raw or saturated per Configuration) and `ovfl`, `zero`, `neg` from the final `diff`.
- **DONE**: `done`=1 for exactly one cycle; unconditionally return to IDLE.

Rules:
- `start` in RUN or DONE is ignored, not queued.
- `diff`/flags hold their values until the next finalize; they are not cleared on accept.
- Final carry-out is not exported. Borrow = ~carry, unused.
- Arithmetic is mod 2^16; no widening.

## Timing
- Start accepted at edge k.
- Nibbles 0..3 computed at edges k+1..k+4; finalize at k+4.
- `done`=1 in cycle (k+4, k+5]; IDLE after k+5.
- Start-to-done latency: 5 cycles. Throughput: one op per 6 cycles (next start accepted at edge k+6 earliest).
- `busy` rises after edge k and falls after edge k+5.
- Reset values:
  - state=IDLE, `idx`=0, `carry_q`=0.
  - `busy`=0, `done`=0, `diff`=0x0000, `ovfl`=0, `zero`=0, `neg`=0.
- Reset asserted mid-RUN/DONE: immediate return to reset values; the partial result is discarded and no `done` pulse is produced.

## Configuration
- `NIBBLE_SUB_SAT_EN` defined: on V=1, `diff` = 0x7FFF if `a[15]`=0, 0x8000 if `a[15]`=1. Flags are computed from the saturated `diff`; `ovfl` still = V.
- Undefined: `diff` = raw wrapped result; `ovfl` still reports V.

## Structure
- Package `nibble_sub_pkg` contains:
  - `state_t` enum {IDLE, RUN, DONE}.
  - `NIB_W`=4, `NUM_NIB`=4, `DATA_W`=16.
  - `SAT_POS`=16'h7FFF, `SAT_NEG`=16'h8000.
- One sub-module, `sub_slice4`: combinational 4-bit CLA slice (a, b, cin → sum, cout), instantiated once.
- The top level holds the FSM, the shift/index registers and the finalize logic.

## Test plan
- 0x0005 − 0x0003 → `diff`=0x0002, V=0, Z=0, N=0; `done` exactly 5 cycles after start.
- 0x1234 − 0x1234 → `diff`=0x0000, Z=1, V=0.
- 0x7FFF − 0xFFFF → V=1; `diff`=0x7FFF with SAT_EN, 0x8000 without (N=1).
- 0x8000 − 0x0001 → V=1; `diff`=0x8000 with SAT_EN, 0x7FFF without.
- Second `start` (0x0001 − 0x0001) pulsed during RUN → ignored: one `done` only, `diff` from the first op; the next start is accepted only after DONE.
- `rst` pulsed at the second RUN cycle → `busy`=0, `diff`=0 immediately, no `done`; a fresh op then completes normally.
